// File: rtl/gate_sweep_unit.sv
// Sweeps all 2^N input vectors through an N-input gate selected by op and captures the truth table.
// Optional self-check against exp_table is built only when SWEEP_SELFCHECK_EN is defined.
module gate_sweep_unit #(
  parameter int N    = 3,
  parameter int HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [2**N-1:0]  exp_table,
  output logic [N-1:0]     vec,
  output logic             y,
  output logic [2**N-1:0]  table_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t       state, state_next;
  logic [7:0]   hold_cnt;
  logic [2:0]   op_q;
  logic         capture;
  logic         last;
  logic [W-1:0] table_next;

  // Gate under observation; reserved opcodes read as constant 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    y = 1'b0;
    case (op_q)
      3'd0:    y =  (&vec);
      3'd1:    y =  (|vec);
      3'd2:    y = ~(&vec);
      3'd3:    y = ~(|vec);
      3'd4:    y =  (^vec);
      3'd5:    y = ~(^vec);
      default: y = 1'b0;
    endcase
  end

  assign capture = (state == SWEEP) && (hold_cnt == 8'(HOLD - 1));
  assign last    = capture && (vec == {N{1'b1}});
  assign busy    = (state == SWEEP);
  assign done    = (state == DONE);

  // Table as it will look after this edge, so the self-check sees the final bit too.
  always_comb begin
    table_next = table_q;
    if (capture) table_next[vec] = y;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP:   if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: table_q is a plain register, not a memory, so it is reset like any other flop.
      vec      <= '0;
      hold_cnt <= '0;
      op_q     <= '0;
      table_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            table_q  <= '0;
            vec      <= '0;
            hold_cnt <= '0;
          end
        end
        SWEEP: begin
          table_q <= table_next;
          if (capture) begin
            hold_cnt <= '0;
            vec      <= last ? '0 : vec + N'(1);
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_SELFCHECK_EN
  logic [W-1:0] exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= '0;
      mismatch <= 1'b0;
    end else if (state == IDLE && start) begin
      exp_q    <= exp_table;
      mismatch <= 1'b0;
    end else if (last) begin
      mismatch <= (table_next != exp_q);
    end
  end
`else
  logic unused_exp;
  assign unused_exp = ^exp_table;
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Directed bench for gate_sweep_unit: instance a (HOLD=1) and instance b (HOLD=2), both N=3.
module tb_gate_sweep_unit;

`ifdef SWEEP_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] exp_table = 8'h00;

  logic [2:0] vec_a, vec_b;
  logic       y_a, y_b, busy_a, busy_b, done_a, done_b, mm_a, mm_b;
  logic [7:0] table_a, table_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_sweep_unit #(.N(3), .HOLD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op), .exp_table(exp_table),
    .vec(vec_a), .y(y_a), .table_q(table_a), .busy(busy_a), .done(done_a), .mismatch(mm_a)
  );

  gate_sweep_unit #(.N(3), .HOLD(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op), .exp_table(exp_table),
    .vec(vec_b), .y(y_b), .table_q(table_b), .busy(busy_b), .done(done_b), .mismatch(mm_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Full HOLD=1 sweep on instance a; poke re-pulses start at vec=3 and in the DONE cycle.
  task automatic sweep_a(input logic [2:0] o, input logic [7:0] e, input logic [7:0] want,
                         input logic mm, input bit poke, input string tag);
    @(negedge clk);
    op = o; exp_table = e; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0; op = 3'd6; exp_table = ~e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check({tag, " vec"}, vec_a, i);
      check({tag, " y"}, y_a, want[i]);
      check({tag, " busy"}, busy_a, 1);
      check({tag, " done early"}, done_a, 0);
      if (i == 0) check({tag, " mm cleared"}, mm_a, 0);
      start_a = poke && (i == 3);
    end
    @(negedge clk);
    check({tag, " done"}, done_a, 1);
    check({tag, " busy off"}, busy_a, 0);
    check({tag, " table"}, table_a, want);
    check({tag, " mismatch"}, mm_a, mm);
    start_a = poke;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, " done pulse"}, done_a, 0);
    check({tag, " table held"}, table_a, want);
    check({tag, " mm held"}, mm_a, mm);
    @(negedge clk);
    check({tag, " idle"}, busy_a, 0);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset vec", vec_a, 0);
    check("reset y", y_a, 0);
    check("reset table", table_a, 0);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset mm", mm_a, 0);

    sweep_a(3'd0, 8'h80, 8'h80, 1'b0, 1'b0, "and");
    sweep_a(3'd1, 8'hFE, 8'hFE, 1'b0, 1'b0, "or");
    sweep_a(3'd2, 8'h7F, 8'h7F, 1'b0, 1'b0, "nand");
    sweep_a(3'd3, 8'h01, 8'h01, 1'b0, 1'b0, "nor");
    sweep_a(3'd4, 8'h96, 8'h96, 1'b0, 1'b0, "xor");
    sweep_a(3'd5, 8'h69, 8'h69, 1'b0, 1'b0, "xnor");
    sweep_a(3'd6, 8'h00, 8'h00, 1'b0, 1'b0, "rsvd");
    sweep_a(3'd0, 8'h81, 8'h80, SC,   1'b0, "and bad exp");
    sweep_a(3'd0, 8'h80, 8'h80, 1'b0, 1'b1, "and poke");

    // HOLD=2: every vector held two cycles, done 16 cycles after start.
    @(negedge clk);
    op = 3'd4; exp_table = 8'h96; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0; op = 3'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("h2 vec", vec_b, i / 2);
      check("h2 busy", busy_b, 1);
      check("h2 done early", done_b, 0);
    end
    @(negedge clk);
    check("h2 done", done_b, 1);
    check("h2 table", table_b, 8'h96);
    check("h2 mismatch", mm_b, 0);

    // Asynchronous reset mid-sweep at vec=5.
    @(negedge clk);
    op = 3'd1; exp_table = 8'hFE; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("pre-reset vec", vec_a, 5);
    check("pre-reset table", table_a, 8'h1E);
    #2 rst_n = 1'b0;
    #1;
    check("rst vec", vec_a, 0);
    check("rst busy", busy_a, 0);
    check("rst table", table_a, 0);
    check("rst y", y_a, 0);
    check("rst done", done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_a(3'd1, 8'hFE, 8'hFE, 1'b0, 1'b0, "or after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
